// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM states, owner ids
// and the full-word byte mask used for instruction fetches.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Owner / grant ids. A single bit is enough for two requesters.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Fetches always read the whole word.
    localparam logic [3:0] MASK_WORD = 4'hF;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: a lone requester wins, and on a conflict the
// requester that was not granted last time wins. Purely combinational.
module rr_arbiter_2
    import mem_arb_pkg::*;
(
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic last_grant_i,
    output logic grant_o,
    output logic any_o
);

    // Winner selection; grant_o is only meaningful while any_o is high.
    always_comb begin
        any_o   = i_req_i | d_req_i;
        grant_o = OWN_I;
        if (i_req_i && d_req_i) begin
            grant_o = ~last_grant_i;
        end else if (d_req_i) begin
            grant_o = OWN_D;
        end
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Shares one single-port memory between the instruction-fetch and load/store
// ports. One transaction in flight at a time, round-robin grants, and a
// watchdog that aborts a transaction the memory never completes.
module shared_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_request,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_valid,
    output logic [DATA_W-1:0] i_data_out,
    input  logic              d_request,
    input  logic              d_we_re,
    input  logic [3:0]        d_mask,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_data_in,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_data_out,
    output logic              m_request,
    output logic              m_we_re,
    output logic [3:0]        m_mask,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_data_in,
    input  logic              m_valid,
    input  logic [DATA_W-1:0] m_data_out,
    output logic              busy,
    output logic              timeout_err
);

    // Last BUSY cycle allowed before the watchdog fires (counter starts at 0).
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    arb_state_e        state_q;
    logic              owner_q;
    logic              last_grant_q;
    logic [7:0]        cnt_q;
    logic              i_valid_q;
    logic [DATA_W-1:0] i_data_out_q;
    logic              d_valid_q;
    logic [DATA_W-1:0] d_data_out_q;
    logic              m_request_q;
    logic              m_we_re_q;
    logic [3:0]        m_mask_q;
    logic [ADDR_W-1:0] m_address_q;
    logic [DATA_W-1:0] m_data_in_q;
    logic              busy_q;
    logic              timeout_err_q;

    logic              i_req_masked_d;
    logic              d_req_masked_d;
    logic              grant_d;
    logic              any_d;
    logic [DATA_W-1:0] resp_data_d;

    // The owner being answered must not be re-granted off a request it has
    // not yet had the chance to drop.
    assign i_req_masked_d = i_request & ~((state_q == RESP) & (owner_q == OWN_I));
    assign d_req_masked_d = d_request & ~((state_q == RESP) & (owner_q == OWN_D));

    rr_arbiter_2 u_arb (
        .i_req_i      (i_req_masked_d),
        .d_req_i      (d_req_masked_d),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_d),
        .any_o        (any_d)
    );

    // Stores and watchdog aborts return zero; loads return the memory word.
    assign resp_data_d = (m_valid && !m_we_re_q) ? m_data_out : '0;

    // Transaction FSM with latched memory fields, watchdog and response strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            owner_q       <= OWN_I;
            last_grant_q  <= OWN_D;
            cnt_q         <= '0;
            i_valid_q     <= 1'b0;
            i_data_out_q  <= '0;
            d_valid_q     <= 1'b0;
            d_data_out_q  <= '0;
            m_request_q   <= 1'b0;
            m_we_re_q     <= 1'b0;
            m_mask_q      <= '0;
            m_address_q   <= '0;
            m_data_in_q   <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_d) begin
                        owner_q      <= grant_d;
                        last_grant_q <= grant_d;
                        cnt_q        <= '0;
                        state_q      <= BUSY;
                        busy_q       <= 1'b1;
                        m_request_q  <= 1'b1;
                        if (grant_d == OWN_I) begin
                            m_we_re_q   <= 1'b0;
                            m_mask_q    <= MASK_WORD;
                            m_address_q <= i_address;
                            m_data_in_q <= '0;
                        end else begin
                            m_we_re_q   <= d_we_re;
                            m_mask_q    <= d_mask;
                            m_address_q <= d_address;
                            m_data_in_q <= d_data_in;
                        end
                    end
                end
                BUSY: begin
                    // m_valid has priority over a watchdog expiry in the same cycle.
                    if (m_valid || (cnt_q == CNT_LAST)) begin
                        state_q     <= RESP;
                        m_request_q <= 1'b0;
                        m_we_re_q   <= 1'b0;
                        m_mask_q    <= '0;
                        m_address_q <= '0;
                        m_data_in_q <= '0;
                        if (!m_valid) begin
                            timeout_err_q <= 1'b1;
                        end
                        if (owner_q == OWN_I) begin
                            i_valid_q    <= 1'b1;
                            i_data_out_q <= resp_data_d;
                        end else begin
                            d_valid_q    <= 1'b1;
                            d_data_out_q <= resp_data_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    i_valid_q    <= 1'b0;
                    i_data_out_q <= '0;
                    d_valid_q    <= 1'b0;
                    d_data_out_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign i_valid     = i_valid_q;
    assign i_data_out  = i_data_out_q;
    assign d_valid     = d_valid_q;
    assign d_data_out  = d_data_out_q;
    assign m_request   = m_request_q;
    assign m_we_re     = m_we_re_q;
    assign m_mask      = m_mask_q;
    assign m_address   = m_address_q;
    assign m_data_in   = m_data_in_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Two-requester arbiter that shares one single-port memory between the core's instruction-fetch port and its load/store port. It sits between `core` and a single `data_mem_top`-style memory, owns the memory's `request`/`we_re`/`mask` handshake, and returns each response only to the requester that issued it. Arbitration is round-robin, with one transaction outstanding at a time and a watchdog on memory latency.

## Interface
- `ADDR_W`, default 8: word address width into the memory.
- `DATA_W`, default 32: data width.
- `TIMEOUT`, default 255: maximum cycles spent in BUSY before the transaction is aborted (1..255).

Ports:
- `clk` in 1: the single clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_request` in 1: instruction fetch request. The fetch is always a read.
- `i_address` in ADDR_W: fetch word address.
- `i_valid` out 1: one-cycle fetch response strobe.
- `i_data_out` out DATA_W: fetched word, qualified by `i_valid`.
- `d_request` in 1: data request.
- `d_we_re` in 1: 1 = store, 0 = load.
- `d_mask` in 4: byte mask.
- `d_address` in ADDR_W: data word address.
- `d_data_in` in DATA_W: store data.
- `d_valid` out 1: one-cycle data response strobe.
- `d_data_out` out DATA_W: load data, qualified by `d_valid`.
- `m_request`, `m_we_re` out 1: request and direction to the memory.
- `m_mask` out 4: byte mask to the memory.
- `m_address` out ADDR_W: word address to the memory.
- `m_data_in` out DATA_W: store data to the memory.
- `m_valid` in 1: memory completion strobe.
- `m_data_out` in DATA_W: memory read data.
- `busy` out 1: FSM is not in IDLE.
- `timeout_err` out 1: sticky; set on any watchdog abort and cleared only by reset.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any request is present, choose a winner, latch its address/we_re/mask/data and its id into `owner`, then go to BUSY. With no request, stay in IDLE.
- Winner selection: a lone requester wins. On a conflict, the requester other than `last_grant` wins. `last_grant` updates on every grant and resets to D, so the first conflict goes to I.
- Instruction transactions drive `m_we_re`=0 and `m_mask`=4'hF.
- BUSY: `m_request`=1 and all `m_*` fields are held from the latches. The wait counter increments each cycle.
  - On `m_valid`: capture `m_data_out` (forced to 0 for stores) and go to RESP.
  - When the counter reaches TIMEOUT with no `m_valid`: set `timeout_err`, set the captured data to 0, and go to RESP.
- RESP: pulse the `owner`'s valid for exactly one cycle with the captured data, then return to IDLE.
  - The `owner`'s request is masked during RESP so a still-high request is not re-granted.
  - The other requester may be granted on the following IDLE cycle.
- A request dropped during BUSY does not cancel the transaction; the response is still delivered.
- `m_valid` arriving in IDLE or RESP is ignored. This includes a late `m_valid` after a timeout.
- Requesters must hold their request and fields stable until they see their valid. They must deassert the request no later than the cycle after that valid.

## Timing
- Reset (asynchronous, active-low) forces:
  - all outputs to 0;
  - FSM to IDLE, `last_grant` to D, counter to 0, `timeout_err` to 0.
- Reset in BUSY aborts the transaction with no response.
- All outputs are registered.
- Latency: a request seen in IDLE at cycle N gives `m_request` high from N+1. `m_valid` at cycle K gives the requester's valid at K+1, and the next grant decision at K+2 (`m_request` at K+3).
- A memory with 1-cycle latency gives one transaction per 4 cycles.
- Watchdog: with `m_request` rising at N+1, abort gives RESP at N+1+TIMEOUT.
- `m_valid` and the timeout in the same cycle: `m_valid` wins and `timeout_err` is not set.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE/BUSY/RESP);
  - the owner id constants `OWN_I`=0 and `OWN_D`=1;
  - the mask constant `MASK_WORD`=4'hF.
- Sub-module `rr_arbiter_2` is combinational: inputs are the two requests and `last_grant`; outputs are the grant id and `any`. The FSM, latches and watchdog stay in the top.

## Test plan
- Lone fetch, memory `m_valid` 1 cycle after the request, address 8'h04, `m_data_out`=32'h00500093 → `m_request` at N+1; `i_valid`=1 with `i_data_out`=32'h00500093 at K+1; `d_valid` stays 0.
- Store `d_we_re`=1, `d_mask`=4'b0011, `d_address`=8'h10, data 32'hDEADBEEF → `m_*` mirror these values; `d_valid` pulses with `d_data_out`=0.
- Both requests held high continuously → grants alternate I, D, I, D starting with I. No requester is granted twice in a row; each valid pulse lasts exactly 1 cycle.
- TIMEOUT=4 and the memory never responds → `d_valid` pulses with 0 data 4 cycles after `m_request` rises. `timeout_err` stays 1 until reset. A later spurious `m_valid` produces no valid pulse.
- Reset asserted while in BUSY → all outputs are 0 immediately. After release, a pending `d_request` is granted cleanly, with no stale response.
- Spurious `m_valid` in IDLE, plus `m_valid` coinciding with the timeout cycle → no response in IDLE; normal data is returned and `timeout_err` stays 0.
